// File: rtl/cr_kme_fifo_arb.sv
// rtl/cr_kme_fifo_arb.sv - packet-atomic round-robin arbiter feeding the shared KME FIFO
//
// Purpose:
//   Selects one of N_REQ requesters round-robin and forwards its packet
//   beat by beat into the shared KME FIFO. A packet keeps the grant until its
//   last beat, or until MAX_BEATS beats have been moved (truncation). One idle
//   cycle of arbitration precedes every packet.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   arb_en            permits new grants (an in-flight packet always completes)
//   req_valid/last    per-requester beat valid / end-of-packet marker
//   req_data          per-requester beats, requester i at [DATA_SIZE*i +: DATA_SIZE]
//   req_ready         one-hot beat-accept strobe back to the granted requester
//   fifo_in(_valid)   write data / write enable toward the FIFO
//   fifo_in_stall     FIFO full; no beat moves while high
//   fifo_overflow     FIFO overflow pulse, captured into err_ovf
//   err_clr           clears err_len and err_ovf (a coincident set wins)
//   grant_active      high while a packet grant is held
//   grant_id          current or most recent granted requester
//   pkt_cnt           completed packets, wraps at 2^16
//   err_len, err_ovf  sticky truncation / overflow flags

module cr_kme_fifo_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 128,
  parameter int MAX_BEATS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arb_en,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0]             req_last,
  input  logic [N_REQ*DATA_SIZE-1:0]   req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic [DATA_SIZE-1:0]         fifo_in,
  output logic                         fifo_in_valid,
  input  logic                         fifo_in_stall,
  input  logic                         fifo_overflow,
  input  logic                         err_clr,
  output logic                         grant_active,
  output logic [$clog2(N_REQ)-1:0]     grant_id,
  output logic [15:0]                  pkt_cnt,
  output logic                         err_len,
  output logic                         err_ovf
);

  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q;
  logic [IDW-1:0]  grant_id_q;
  logic [IDW-1:0]  last_grant_q;
  logic [7:0]      beat_cnt_q;
  logic [15:0]     pkt_cnt_q;
  logic            grant_active_q;
  logic            err_len_q, err_len_d;
  logic            err_ovf_q, err_ovf_d;

  logic            found;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  idx;
  logic            xfer;
  logic            beat_at_max;
  logic            pkt_end;
  logic            trunc;

  // Round-robin search starting just after the previous grant, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(last_grant_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // The beat path is combinational so the FIFO sees data with zero latency;
  // reset gates it so nothing is written or acknowledged during reset.
  assign xfer        = (state_q == BUSY) & ~rst & req_valid[grant_id_q] & ~fifo_in_stall;
  assign beat_at_max = (beat_cnt_q == 8'(MAX_BEATS - 1));
  assign pkt_end     = xfer & (req_last[grant_id_q] | beat_at_max);
  assign trunc       = xfer & ~req_last[grant_id_q] & beat_at_max;

  assign fifo_in_valid = xfer;
  assign req_ready     = xfer ? (N_REQ'(1) << grant_id_q) : '0;
  assign fifo_in       = req_data[grant_id_q * DATA_SIZE +: DATA_SIZE];

  // Sticky flags: a set in the same cycle as err_clr takes priority.
  assign err_len_d = trunc | (err_len_q & ~err_clr);
  assign err_ovf_d = fifo_overflow | (err_ovf_q & ~err_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_grant_q   <= IDW'(N_REQ - 1);  // requester 0 wins the first search
      beat_cnt_q     <= '0;
      pkt_cnt_q      <= '0;
      grant_active_q <= 1'b0;
      err_len_q      <= 1'b0;
      err_ovf_q      <= 1'b0;
    end else begin
      err_len_q <= err_len_d;
      err_ovf_q <= err_ovf_d;
      case (state_q)
        IDLE: begin
          if (arb_en && found) begin
            state_q        <= BUSY;
            grant_id_q     <= pick;
            beat_cnt_q     <= '0;
            grant_active_q <= 1'b1;
          end
        end
        BUSY: begin
          // arb_en is ignored here: an accepted packet always runs to its end.
          if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
          end
          if (pkt_end) begin
            state_q        <= IDLE;
            last_grant_q   <= grant_id_q;
            pkt_cnt_q      <= pkt_cnt_q + 16'd1;
            grant_active_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= IDLE;
          grant_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_active = grant_active_q;
  assign grant_id     = grant_id_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign err_len      = err_len_q;
  assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_cr_kme_fifo_arb.sv
// tb/tb_cr_kme_fifo_arb.sv - scoreboard testbench for cr_kme_fifo_arb

module tb_cr_kme_fifo_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         arb_en;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [511:0] req_data;
  logic [3:0]   req_ready;
  logic [127:0] fifo_in;
  logic         fifo_in_valid;
  logic         fifo_in_stall;
  logic         fifo_overflow;
  logic         err_clr;
  logic         grant_active;
  logic [1:0]   grant_id;
  logic [15:0]  pkt_cnt;
  logic         err_len;
  logic         err_ovf;

  int checks   = 0;
  int failures = 0;

  logic [128:0] rq [4][$];   // per-requester beats {last, data}
  logic [127:0] exp_q [$];   // scoreboard: expected FIFO write order

  cr_kme_fifo_arb #(.N_REQ(4), .DATA_SIZE(128), .MAX_BEATS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .arb_en       (arb_en),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_in      (fifo_in),
    .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(fifo_in_stall),
    .fifo_overflow(fifo_overflow),
    .err_clr      (err_clr),
    .grant_active (grant_active),
    .grant_id     (grant_id),
    .pkt_cnt      (pkt_cnt),
    .err_len      (err_len),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(int r, int p, int b);
    logic [31:0] w;
    w = {8'hA5, 8'(r), 8'(p), 8'(b)};
    return {w, ~w, w ^ 32'h1234_5678, w};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_pkt(int r, int p, int nb);
    for (int b = 0; b < nb; b++) rq[r].push_back({(b == nb - 1), mk(r, p, b)});
  endtask

  task automatic exp_pkt(int r, int p, int nb);
    for (int b = 0; b < nb; b++) exp_q.push_back(mk(r, p, b));
  endtask

  task automatic drive();
    logic [128:0] h;
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        req_valid[i] = 1'b1;
        req_last[i]  = h[128];
        req_data[i*128 +: 128] = h[127:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*128 +: 128] = '0;
      end
    end
  endtask

  // One clock: capture acceptances before the edge, retire them after it.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size() > 0 || grant_active)
           && n < budget) begin
      step();
      n++;
    end
    chk({name, "_done"}, (n < budget), 1);
  endtask

  // Monitor: every FIFO write is checked against the scoreboard.
  always @(negedge clk) begin
    logic [127:0] e;
    if (fifo_in_valid) begin
      checks++;
      if (fifo_in_stall || rst) begin
        failures++;
        $display("FAIL wr_while_blocked: stall=%0b rst=%0b", fifo_in_stall, rst);
      end
      checks++;
      if (req_ready !== (4'b0001 << grant_id)) begin
        failures++;
        $display("FAIL ready_onehot: got %b expected %b", req_ready, 4'b0001 << grant_id);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected: got %h expected none", fifo_in);
      end else begin
        e = exp_q.pop_front();
        if (fifo_in !== e) begin
          failures++;
          $display("FAIL beat_data: got %h expected %h", fifo_in, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; arb_en = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    fifo_in_stall = 1'b0; fifo_overflow = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_grant_active", grant_active, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_len", err_len, 0);
    chk("rst_err_ovf", err_ovf, 0);

    // Fairness: everyone has two 2-beat packets; order 0,1,2,3,0,1,2,3
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) begin
        add_pkt(r, p, 2);
        exp_pkt(r, p, 2);
      end
    drive();
    repeat (12) step();
    chk("fair_pkt_cnt_12cyc", pkt_cnt, 4);
    chk("fair_grant_id_12cyc", grant_id, 3);
    wait_idle("fair", 200);
    chk("fair_pkt_cnt_end", pkt_cnt, 8);
    chk("fair_sb_empty", exp_q.size(), 0);

    // Stall: requester 2, 3 beats, 5 stalled cycles after the first beat
    add_pkt(2, 0, 3);
    exp_pkt(2, 0, 3);
    drive();
    repeat (2) step();
    fifo_in_stall = 1'b1;
    repeat (5) step();
    chk("stall_grant_active", grant_active, 1);
    chk("stall_grant_id", grant_id, 2);
    chk("stall_beats_left", exp_q.size(), 2);
    fifo_in_stall = 1'b0;
    wait_idle("stall", 50);
    chk("stall_pkt_cnt", pkt_cnt, 9);
    chk("stall_sb_empty", exp_q.size(), 0);

    // Truncation at MAX_BEATS=4: requester 1 sends 6 beats
    add_pkt(1, 0, 6);
    exp_pkt(1, 0, 6);
    drive();
    repeat (5) step();
    chk("trunc_err_len", err_len, 1);
    chk("trunc_pkt_cnt1", pkt_cnt, 10);
    chk("trunc_idle", grant_active, 0);
    wait_idle("trunc", 50);
    chk("trunc_pkt_cnt2", pkt_cnt, 11);
    chk("trunc_err_len_hold", err_len, 1);
    chk("trunc_sb_empty", exp_q.size(), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_len_clr", err_len, 0);

    // Exactly MAX_BEATS with last on the final beat is not a truncation
    add_pkt(0, 0, 4);
    exp_pkt(0, 0, 4);
    drive();
    wait_idle("maxlen", 50);
    chk("maxlen_err_len", err_len, 0);
    chk("maxlen_pkt_cnt", pkt_cnt, 12);

    // arb_en dropped during requester 0's packet
    add_pkt(0, 1, 3);
    exp_pkt(0, 1, 3);
    drive();
    step();
    chk("arben_grant_r0", grant_id, 0);
    arb_en = 1'b0;
    add_pkt(3, 0, 1);
    exp_pkt(3, 0, 1);
    drive();
    repeat (3) step();
    chk("arben_pkt_done", pkt_cnt, 13);
    repeat (3) step();
    chk("arben_no_grant", grant_active, 0);
    chk("arben_r3_waiting", exp_q.size(), 1);
    arb_en = 1'b1;
    step();
    chk("arben_reen_active", grant_active, 1);
    chk("arben_reen_id", grant_id, 3);
    step();
    chk("single_beat_done", grant_active, 0);
    chk("single_beat_pkt_cnt", pkt_cnt, 14);
    chk("arben_sb_empty", exp_q.size(), 0);

    // Reset on the 2nd beat of requester 1's packet
    add_pkt(1, 1, 3);
    exp_q.push_back(mk(1, 1, 0));
    drive();
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_zero", req_ready, 0);
    chk("rst_valid_zero", fifo_in_valid, 0);
    step();
    rq[1].delete();
    drive();
    rst = 1'b0;
    chk("rst_mid_idle", grant_active, 0);
    chk("rst_mid_pkt_cnt", pkt_cnt, 0);
    chk("rst_mid_sb_empty", exp_q.size(), 0);

    // Overflow set coincident with clear: set wins
    fifo_overflow = 1'b1;
    err_clr = 1'b1;
    step();
    fifo_overflow = 1'b0;
    err_clr = 1'b0;
    chk("ovf_set_wins", err_ovf, 1);
    step();
    chk("ovf_sticky", err_ovf, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_cleared", err_ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
